// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state encoding and line-level constants for the PISO framer
package piso_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } piso_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/piso_framer.sv
// rtl/piso_framer.sv - parallel-in serial-out framer: start, data, optional even parity, stop
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-low reset
//   din       parallel word, captured on an accepted handshake
//   in_valid  source presents a word on din
//   in_ready  framer accepts a word this cycle (IDLE or STOP, not in reset)
//   sout      registered serial line, idles high
//   busy      a frame is on the line (START..STOP)
//   done      high during the stop-bit cycle only
module piso_framer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int PARITY_EN = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    piso_state_t      state, state_nx;
    logic [WIDTH-1:0] shreg, shreg_nx, shreg_shifted;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             par_q, par_nx;
    logic             sout_q, sout_nx;
    logic             accept;
    logic             data_bit;

    assign in_ready = rst && (state == IDLE || state == STOP);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);
    assign done     = (state == STOP);
    assign sout     = sout_q;

    // The bit about to go on the line always sits at the outgoing end of the shift register.
    assign data_bit      = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
    assign shreg_shifted = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                            : {1'b0, shreg[WIDTH-1:1]};

    // sout is registered, so each branch loads the level the line must show in the next state.
    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        cnt_nx   = cnt;
        par_nx   = par_q;
        sout_nx  = sout_q;
        case (state)
            IDLE: begin
                sout_nx = LINE_IDLE;
                if (accept) begin
                    state_nx = START;
                    shreg_nx = din;
                    par_nx   = ^din;
                    cnt_nx   = '0;
                    sout_nx  = START_BIT;
                end
            end
            START: begin
                state_nx = DATA;
                sout_nx  = data_bit;
                shreg_nx = shreg_shifted;
                cnt_nx   = '0;
            end
            DATA: begin
                // cnt numbers the data bit currently on the line.
                if (cnt == CNT_LAST) begin
                    if (PARITY_EN != 0) begin
                        state_nx = PARITY;
                        sout_nx  = par_q;
                    end else begin
                        state_nx = STOP;
                        sout_nx  = STOP_BIT;
                    end
                end else begin
                    sout_nx  = data_bit;
                    shreg_nx = shreg_shifted;
                    cnt_nx   = cnt + 1'b1;
                end
            end
            PARITY: begin
                state_nx = STOP;
                sout_nx  = STOP_BIT;
            end
            STOP: begin
                if (accept) begin
                    state_nx = START;
                    shreg_nx = din;
                    par_nx   = ^din;
                    cnt_nx   = '0;
                    sout_nx  = START_BIT;
                end else begin
                    state_nx = IDLE;
                    sout_nx  = LINE_IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                sout_nx  = LINE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            par_q  <= 1'b0;
            sout_q <= LINE_IDLE;
        end else begin
            state  <= state_nx;
            shreg  <= shreg_nx;
            cnt    <= cnt_nx;
            par_q  <= par_nx;
            sout_q <= sout_nx;
        end
    end

endmodule

// File: tb/tb_piso_framer.sv
// tb/tb_piso_framer.sv - scoreboard bench for piso_framer (parity/MSB-first and plain/LSB-first builds)
module tb_piso_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din_a, din_b;
    logic       valid_a, valid_b;
    logic       ready_a, ready_b, sout_a, sout_b, busy_a, busy_b, done_a, done_b;

    always #5 clk = ~clk;

    piso_framer #(.WIDTH(4), .PARITY_EN(1), .MSB_FIRST(1)) dut_a (
        .clk(clk), .rst(rst), .din(din_a), .in_valid(valid_a), .in_ready(ready_a),
        .sout(sout_a), .busy(busy_a), .done(done_a)
    );

    piso_framer #(.WIDTH(4), .PARITY_EN(0), .MSB_FIRST(0)) dut_b (
        .clk(clk), .rst(rst), .din(din_b), .in_valid(valid_b), .in_ready(ready_b),
        .sout(sout_b), .busy(busy_b), .done(done_b)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Serial bit i of the frame lands in bit i; positions past the frame stay at the idle level.
    function automatic logic [7:0] frame_bits(input logic [3:0] d, input bit par, input bit msb);
        logic [7:0] f;
        f    = 8'hff;
        f[0] = 1'b0;
        for (int i = 0; i < 4; i++) f[1+i] = msb ? d[3-i] : d[i];
        if (par) f[5] = ^d;
        return f;
    endfunction

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    int         pos_a = 0, pos_b = 0;
    logic [7:0] cap_a, cap_b, exp_f;
    bit         bad_a, bad_b, idle_bad_a = 0, idle_bad_b = 0;

    // Frame monitors: sample mid-cycle, compare each complete frame against the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (pos_a != 0 && q_a.size() > 0) void'(q_a.pop_front());
            if (pos_b != 0 && q_b.size() > 0) void'(q_b.pop_front());
            pos_a = 0;
            pos_b = 0;
        end else begin
            if (pos_a == 0 && !busy_a && (sout_a !== 1'b1 || done_a !== 1'b0)) idle_bad_a = 1;
            if (pos_a == 0 && busy_a) begin cap_a = 8'hff; bad_a = 0; end
            if (pos_a != 0 || busy_a) begin
                cap_a[pos_a] = sout_a;
                if (busy_a !== 1'b1 || done_a !== (pos_a == 6)) bad_a = 1;
                if (pos_a == 6) begin
                    check_eq("queue_a_nonempty", 16'(q_a.size() > 0), 16'd1);
                    if (q_a.size() > 0) begin
                        exp_f = q_a.pop_front();
                        check_eq("frame_a", 16'(cap_a), 16'(exp_f));
                    end
                    check_eq("busy_done_a", 16'(bad_a), 16'd0);
                    pos_a = 0;
                end else pos_a++;
            end

            if (pos_b == 0 && !busy_b && (sout_b !== 1'b1 || done_b !== 1'b0)) idle_bad_b = 1;
            if (pos_b == 0 && busy_b) begin cap_b = 8'hff; bad_b = 0; end
            if (pos_b != 0 || busy_b) begin
                cap_b[pos_b] = sout_b;
                if (busy_b !== 1'b1 || done_b !== (pos_b == 5)) bad_b = 1;
                if (pos_b == 5) begin
                    check_eq("queue_b_nonempty", 16'(q_b.size() > 0), 16'd1);
                    if (q_b.size() > 0) begin
                        exp_f = q_b.pop_front();
                        check_eq("frame_b", 16'(cap_b), 16'(exp_f));
                    end
                    check_eq("busy_done_b", 16'(bad_b), 16'd0);
                    pos_b = 0;
                end else pos_b++;
            end

            // Expectations are queued at the handshake, before the accepting edge.
            if (valid_a && ready_a) q_a.push_back(frame_bits(din_a, 1'b1, 1'b1));
            if (valid_b && ready_b) q_b.push_back(frame_bits(din_b, 1'b0, 1'b0));
        end
    end

    // Downstream deserializer on sout_a: start, 4 data bits MSB first, parity, stop.
    int         rx_pos = 0;
    logic [3:0] rx_word = 4'h0, rx_sh = 4'h0;
    always @(negedge clk) begin
        if (!rst) rx_pos = 0;
        else if (rx_pos == 0) begin
            if (sout_a == 1'b0) rx_pos = 1;
        end else begin
            if (rx_pos <= 4) rx_sh = {rx_sh[2:0], sout_a};
            if (rx_pos == 4) rx_word = rx_sh;
            rx_pos = (rx_pos == 6) ? 0 : rx_pos + 1;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a word, wait (bounded) for in_ready, return just after the accepting edge.
    task automatic send(input bit b, input logic [3:0] d);
        int t = 0;
        if (b) begin din_b = d; valid_b = 1'b1; end
        else   begin din_a = d; valid_a = 1'b1; end
        #1;
        while (((b ? ready_b : ready_a) !== 1'b1) && t < 50) begin tick(); t++; end
        check_eq(b ? "ready_b_wait" : "ready_a_wait", 16'(b ? ready_b : ready_a), 16'd1);
        tick();
        if (b) valid_b = 1'b0; else valid_a = 1'b0;
    endtask

    initial begin
        rst = 1'b0; din_a = '0; din_b = '0; valid_a = 1'b0; valid_b = 1'b0;
        tick(2);
        check_eq("rst_sout", 16'(sout_a), 16'd1);
        check_eq("rst_busy", 16'(busy_a), 16'd0);
        check_eq("rst_done", 16'(done_a), 16'd0);
        check_eq("rst_ready", 16'(ready_a), 16'd0);
        rst = 1'b1;
        #1;
        check_eq("idle_ready", 16'(ready_a), 16'd1);

        // Basic frame and parity/order variants.
        send(1'b0, 4'b1011);
        tick(8);
        check_eq("after_frame_sout", 16'(sout_a), 16'd1);
        check_eq("after_frame_busy", 16'(busy_a), 16'd0);
        send(1'b0, 4'b0110);
        tick(8);
        send(1'b1, 4'b0001);
        tick(8);

        // Back-to-back: second word waits through the first frame, accepted in STOP.
        send(1'b0, 4'b1111);
        din_a = 4'b0000; valid_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("ready_in_data", 16'(ready_a), 16'd0);
        end
        tick(2);
        check_eq("stop_ready", 16'(ready_a), 16'd1);
        check_eq("stop_done", 16'(done_a), 16'd1);
        tick();
        valid_a = 1'b0;
        check_eq("b2b_start_sout", 16'(sout_a), 16'd0);
        check_eq("b2b_start_busy", 16'(busy_a), 16'd1);
        tick(8);

        // A word offered mid-frame is ignored.
        send(1'b0, 4'b0011);
        tick();
        din_a = 4'b1010; valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        tick(8);
        check_eq("ignored_busy", 16'(busy_a), 16'd0);

        // Reset during the 2nd data bit aborts the frame.
        send(1'b0, 4'b1011);
        tick(2);
        rst = 1'b0;
        tick();
        check_eq("abort_sout", 16'(sout_a), 16'd1);
        check_eq("abort_busy", 16'(busy_a), 16'd0);
        check_eq("abort_done", 16'(done_a), 16'd0);
        tick();
        check_eq("abort_done_hold", 16'(done_a), 16'd0);
        rst = 1'b1;
        #1;
        send(1'b0, 4'b1110);
        tick(8);
        check_eq("rx_word_1110", 16'(rx_word), 16'(4'b1110));

        // Loopback into the downstream deserializer.
        send(1'b0, 4'b1011);
        tick(8);
        check_eq("rx_word_1011", 16'(rx_word), 16'(4'b1011));
        check_eq("rx_idle_line", 16'(sout_a), 16'd1);

        check_eq("queue_a_drained", 16'(q_a.size()), 16'd0);
        check_eq("queue_b_drained", 16'(q_b.size()), 16'd0);
        check_eq("idle_line_a", 16'(idle_bad_a), 16'd0);
        check_eq("idle_line_b", 16'(idle_bad_b), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
